// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: the raster advance request going in, position counters
// and sync/qualifier/pulse outputs coming out of video_timing_gen.
interface video_timing_gen_if;
  logic        enable;
  logic [11:0] pixel_cnt;
  logic [11:0] line_cnt;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  enable,
    output pixel_cnt,
    output line_cnt,
    output video_on,
    output hsync,
    output vsync,
    output line_start,
    output frame_start
  );

  modport slave (
    output enable,
    input  pixel_cnt,
    input  line_cnt,
    input  video_on,
    input  hsync,
    input  vsync,
    input  line_start,
    input  frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, one phase FSM per axis, and registered
// outputs decoded from next state so they always match the counters of the same cycle.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 248,
  parameter int   V_ACTIVE = 1024,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 38,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1
) (
  input  logic              rfr_clk,
  input  logic              reset_n,
  video_timing_gen_if.master vt_if
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > 4096) || (V_TOTAL > 4096)) begin : g_param_err
    $error("video_timing_gen: H_TOTAL and V_TOTAL must both be <= 4096");
  end

  localparam logic [11:0] L_H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] L_V_LAST = 12'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic [11:0]      r_pixel_cnt;
  logic [11:0]      r_line_cnt;
  logic [11:0]      w_pixel_next;
  logic [11:0]      w_line_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [1:0][1:0]  w_phase_next;   // [0] horizontal, [1] vertical

  logic             r_video_on;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_line_start;
  logic             r_frame_start;

  always_comb begin
    w_h_wrap     = (r_pixel_cnt == L_H_LAST);
    w_v_wrap     = (r_line_cnt == L_V_LAST);
    w_pixel_next = r_pixel_cnt;
    w_line_next  = r_line_cnt;
    if (vt_if.enable) begin
      if (w_h_wrap) begin
        w_pixel_next = '0;
        w_line_next  = w_v_wrap ? '0 : r_line_cnt + 12'd1;
      end else begin
        w_pixel_next = r_pixel_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel_cnt <= L_H_LAST;
      r_line_cnt  <= L_V_LAST;
    end else begin
      r_pixel_cnt <= w_pixel_next;
      r_line_cnt  <= w_line_next;
    end
  end

  // Both axes share one phase machine shape; only the count source, the advance
  // condition and the boundaries differ. The V machine steps only on the H wrap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_phase
    localparam logic [11:0] L_END_ACTIVE = (gi == 0) ? 12'(H_ACTIVE - 1)
                                                     : 12'(V_ACTIVE - 1);
    localparam logic [11:0] L_END_FRONT  = (gi == 0) ? 12'(H_ACTIVE + H_FP - 1)
                                                     : 12'(V_ACTIVE + V_FP - 1);
    localparam logic [11:0] L_END_SYNC   = (gi == 0) ? 12'(H_ACTIVE + H_FP + H_SYNC - 1)
                                                     : 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] L_END_BACK   = (gi == 0) ? L_H_LAST : L_V_LAST;

    logic [11:0] w_cnt;
    logic        w_adv;
    phase_t      r_state;
    phase_t      w_state_next;

    assign w_cnt = (gi == 0) ? r_pixel_cnt : r_line_cnt;
    assign w_adv = (gi == 0) ? vt_if.enable : (vt_if.enable && w_h_wrap);

    always_ff @(posedge rfr_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= PH_BACK;
      end else begin
        r_state <= w_state_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      if (w_adv) begin
        unique case (r_state)
          PH_ACTIVE: if (w_cnt == L_END_ACTIVE) w_state_next = PH_FRONT;
          PH_FRONT:  if (w_cnt == L_END_FRONT)  w_state_next = PH_SYNC;
          PH_SYNC:   if (w_cnt == L_END_SYNC)   w_state_next = PH_BACK;
          PH_BACK:   if (w_cnt == L_END_BACK)   w_state_next = PH_ACTIVE;
          default:                              w_state_next = PH_BACK;
        endcase
      end
    end

    assign w_phase_next[gi] = w_state_next;
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_video_on    <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_video_on    <= (phase_t'(w_phase_next[0]) == PH_ACTIVE) &&
                       (phase_t'(w_phase_next[1]) == PH_ACTIVE);
      r_hsync       <= (phase_t'(w_phase_next[0]) == PH_SYNC) ? H_POL : ~H_POL;
      r_vsync       <= (phase_t'(w_phase_next[1]) == PH_SYNC) ? V_POL : ~V_POL;
      r_line_start  <= vt_if.enable && (w_pixel_next == 12'd0);
      r_frame_start <= vt_if.enable && (w_pixel_next == 12'd0) && (w_line_next == 12'd0);
    end
  end

  assign vt_if.pixel_cnt   = r_pixel_cnt;
  assign vt_if.line_cnt    = r_line_cnt;
  assign vt_if.video_on    = r_video_on;
  assign vt_if.hsync       = r_hsync;
  assign vt_if.vsync       = r_vsync;
  assign vt_if.line_start  = r_line_start;
  assign vt_if.frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 1280x1024 timing and a 14x8 small raster side by side,
// with a position-based reference model feeding per-DUT queues and a negedge monitor.
module tb_video_timing_gen;

  localparam int D_HA = 1280, D_HF = 48, D_HS = 112, D_HB = 248;
  localparam int D_VA = 1024, D_VF = 1,  D_VS = 3,   D_VB = 38;
  localparam int D_HT = 1688, D_VT = 1066;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 1;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = 14, S_VT = 8;

  typedef struct packed {
    logic [11:0] pix;
    logic [11:0] line;
    logic        von;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstd_n;
  logic rsts_n;

  video_timing_gen_if vt_d ();
  video_timing_gen_if vt_s ();

  video_timing_gen u_dut_d (
    .rfr_clk (clk),
    .reset_n (rstd_n),
    .vt_if   (vt_d)
  );

  video_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .H_POL    (1'b0), .V_POL (1'b0)
  ) u_dut_s (
    .rfr_clk (clk),
    .reset_n (rsts_n),
    .vt_if   (vt_s)
  );

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  obs_t q_d[$];
  obs_t q_s[$];

  int   d_pix, d_line, s_pix, s_line;
  logic d_ls, d_fs, s_ls, s_fs;

  // line-0 statistics of the default raster, gathered on distinct pixels only
  int   d_prev_pix  = -1;
  logic d_line0_done = 1'b0;
  int   d_von_px = 0, d_hs_px = 0, d_hs_first = -1, d_hs_last = -1;

  // small raster frame period, counted in position changes between frame_start pulses
  obs_t s_prev;
  logic s_prev_ok  = 1'b0;
  logic s_fs_seen  = 1'b0;
  int   s_steps    = 0;
  int   s_periods  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_obs(input string name, input obs_t a, input obs_t e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got pix=%0d line=%0d von=%b hs=%b vs=%b ls=%b fs=%b, expected pix=%0d line=%0d von=%b hs=%b vs=%b ls=%b fs=%b",
                  name, a.pix, a.line, a.von, a.hs, a.vs, a.ls, a.fs,
                  e.pix, e.line, e.von, e.hs, e.vs, e.ls, e.fs);
  endtask

  function automatic obs_t decode(input int pix, input int line, input logic ls, input logic fs,
                                  input int ha, input int hf, input int hsw,
                                  input int va, input int vf, input int vsw,
                                  input logic hp, input logic vp);
    obs_t o;
    o.pix  = 12'(pix);
    o.line = 12'(line);
    o.von  = (pix < ha) && (line < va);
    o.hs   = ((pix >= ha + hf) && (pix < ha + hf + hsw)) ? hp : ~hp;
    o.vs   = ((line >= va + vf) && (line < va + vf + vsw)) ? vp : ~vp;
    o.ls   = ls;
    o.fs   = fs;
    return o;
  endfunction

  task automatic step(inout int pix, inout int line, inout logic ls, inout logic fs,
                      input logic en, input logic rn, input int ht, input int vt);
    if (!rn) begin
      pix = ht - 1; line = vt - 1; ls = 1'b0; fs = 1'b0;
    end else if (en) begin
      if (pix == ht - 1) begin
        pix  = 0;
        line = (line == vt - 1) ? 0 : line + 1;
      end else begin
        pix++;
      end
      ls = (pix == 0);
      fs = (pix == 0) && (line == 0);
    end else begin
      ls = 1'b0; fs = 1'b0;
    end
  endtask

  function automatic logic rnd_en();
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One clock: advance both models with the inputs in force at this edge, then apply the
  // next inputs 1 ns later (a reset asserted here acts immediately) and queue expectations.
  task automatic tick(input logic ed, input logic rd, input logic es, input logic rs);
    @(posedge clk);
    step(d_pix, d_line, d_ls, d_fs, vt_d.enable, rstd_n, D_HT, D_VT);
    step(s_pix, s_line, s_ls, s_fs, vt_s.enable, rsts_n, S_HT, S_VT);
    #1;
    vt_d.enable = ed;
    rstd_n      = rd;
    vt_s.enable = es;
    rsts_n      = rs;
    if (!rd) step(d_pix, d_line, d_ls, d_fs, 1'b0, 1'b0, D_HT, D_VT);
    if (!rs) step(s_pix, s_line, s_ls, s_fs, 1'b0, 1'b0, S_HT, S_VT);
    q_d.push_back(decode(d_pix, d_line, d_ls, d_fs, D_HA, D_HF, D_HS, D_VA, D_VF, D_VS, 1'b1, 1'b1));
    q_s.push_back(decode(s_pix, s_line, s_ls, s_fs, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b0, 1'b0));
  endtask

  task automatic run_d_until(input int line, input int pix);
    int guard;
    guard = 0;
    while (!((d_line == line) && (d_pix == pix)) && (guard < 10000)) begin
      tick(1'b1, 1'b1, rnd_en(), 1'b1);
      guard++;
    end
    chk("run_until_bound", int'(guard < 10000), 1);
  endtask

  // monitor: pops one expectation per DUT per cycle, sampled on the falling edge
  initial begin
    obs_t a;
    obs_t e;
    forever begin
      @(negedge clk);
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        a.pix = vt_d.pixel_cnt; a.line = vt_d.line_cnt; a.von = vt_d.video_on;
        a.hs  = vt_d.hsync;     a.vs   = vt_d.vsync;    a.ls  = vt_d.line_start;
        a.fs  = vt_d.frame_start;
        chk_obs("default_raster", a, e);
        if (a.line == 12'd1) d_line0_done = 1'b1;
        if (!d_line0_done && (a.line == 12'd0) && (int'(a.pix) != d_prev_pix)) begin
          if (a.von) d_von_px++;
          if (a.hs) begin
            d_hs_px++;
            if (d_hs_first < 0) d_hs_first = int'(a.pix);
            d_hs_last = int'(a.pix);
          end
        end
        d_prev_pix = int'(a.pix);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        a.pix = vt_s.pixel_cnt; a.line = vt_s.line_cnt; a.von = vt_s.video_on;
        a.hs  = vt_s.hsync;     a.vs   = vt_s.vsync;    a.ls  = vt_s.line_start;
        a.fs  = vt_s.frame_start;
        chk_obs("small_raster", a, e);
        if (s_prev_ok && ((a.pix != s_prev.pix) || (a.line != s_prev.line))) s_steps++;
        if (a.fs) begin
          if (s_fs_seen) begin
            chk("small_frame_period", s_steps, 112);
            s_periods++;
          end
          s_fs_seen = 1'b1;
          s_steps   = 0;
        end
        s_prev    = a;
        s_prev_ok = 1'b1;
      end
    end
  end

  initial begin
    vt_d.enable = 1'b0;
    vt_s.enable = 1'b0;
    rstd_n      = 1'b0;
    rsts_n      = 1'b0;
    step(d_pix, d_line, d_ls, d_fs, 1'b0, 1'b0, D_HT, D_VT);
    step(s_pix, s_line, s_ls, s_fs, 1'b0, 1'b0, S_HT, S_VT);

    $display("tb: reset held for 3 cycles, expecting 1687/1065 and 13/7");
    repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0);

    $display("tb: reset released with enable high, next edge goes to (0,0)");
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b1, rnd_en(), 1'b1);

    $display("tb: default raster enable hold at pixel 500 for 10 edges");
    run_d_until(0, 499);
    tick(1'b0, 1'b1, rnd_en(), 1'b1);
    repeat (9) tick(1'b0, 1'b1, rnd_en(), 1'b1);
    tick(1'b1, 1'b1, rnd_en(), 1'b1);
    repeat (3) tick(1'b1, 1'b1, rnd_en(), 1'b1);

    $display("tb: default raster enable hold on the wrap pixel 1687");
    run_d_until(0, 1686);
    tick(1'b0, 1'b1, rnd_en(), 1'b1);
    repeat (4) tick(1'b0, 1'b1, rnd_en(), 1'b1);
    tick(1'b1, 1'b1, rnd_en(), 1'b1);
    repeat (4) tick(1'b1, 1'b1, rnd_en(), 1'b1);

    $display("tb: default raster reset asserted between edges at line 2 pixel 300");
    run_d_until(2, 299);
    tick(1'b1, 1'b0, rnd_en(), 1'b1);
    tick(1'b1, 1'b0, rnd_en(), 1'b1);
    tick(1'b1, 1'b1, rnd_en(), 1'b1);
    repeat (5) tick(1'b1, 1'b1, rnd_en(), 1'b1);

    $display("tb: small raster extra run with random enable gaps");
    repeat (600) tick(1'b1, 1'b1, rnd_en(), 1'b1);

    @(negedge clk);
    #1;
    chk("queue_drained_d", q_d.size(), 0);
    chk("queue_drained_s", q_s.size(), 0);
    chk("line0_video_on_pixels", d_von_px, 1280);
    chk("line0_hsync_pixels", d_hs_px, 112);
    chk("line0_hsync_first", d_hs_first, 1328);
    chk("line0_hsync_last", d_hs_last, 1439);
    chk("small_frames_measured", int'(s_periods >= 3), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
